// File: rtl/des_key_sched_seq.sv
`default_nettype none
// ============================================================================
// Module      : des_key_sched_seq
// Description : Sequential DES key schedule, one subkey per handshake,
//               K1..K16 (encrypt) or K16..K1 (decrypt) without a subkey store.
// Revision    : 1.0 - initial release
// ============================================================================
module des_key_sched_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [32:1] key_high,
    input  logic [32:1] key_low,
    output logic [48:1] subkey,
    output logic [5:1]  subkey_round,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic        busy,
    output logic        done
);

    localparam int C_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int C_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_mode;
    logic [56:1] r_cd;
    logic [64:1] w_key;
    logic [56:1] w_pc1;
    logic [56:1] w_next_cd;
    logic [48:1] w_next_subkey;
    logic        w_rot_two;
    logic        w_last;
    logic        w_unused_parity;

    function automatic logic [28:1] rotl28(input logic [28:1] v, input logic two);
        return two ? {v[26:1], v[28:27]} : {v[27:1], v[28]};
    endfunction

    function automatic logic [28:1] rotr28(input logic [28:1] v, input logic two);
        return two ? {v[2:1], v[28:3]} : {v[1], v[28:2]};
    endfunction

    // Rounds 1, 2, 9 and 16 rotate by one; all others by two.
    function automatic logic shift_is_two(input logic [5:1] r);
        return !((r == 5'd1) || (r == 5'd2) || (r == 5'd9) || (r == 5'd16));
    endfunction

    // DES numbers key bits MSB-first: DES bit i lives at w_key[65-i].
    assign w_key = {key_high, key_low};
    assign w_unused_parity = ^{w_key[57], w_key[49], w_key[41], w_key[33],
                               w_key[25], w_key[17], w_key[9],  w_key[1]};

    for (genvar j = 1; j <= 56; j++) begin : g_pc1
        assign w_pc1[57-j] = w_key[65-C_PC1[j-1]];
    end

    for (genvar j = 1; j <= 48; j++) begin : g_pc2
        assign w_next_subkey[49-j] = w_next_cd[57-C_PC2[j-1]];
    end

    always_comb begin
        w_rot_two = r_mode ? shift_is_two(subkey_round)
                           : shift_is_two(subkey_round + 5'd1);
        w_next_cd = r_cd;
        if (r_state == S_IDLE) begin
            // Decrypt starts from C0/D0 directly since the shifts total 28.
            w_next_cd = decrypt ? w_pc1
                                : {rotl28(w_pc1[56:29], 1'b0), rotl28(w_pc1[28:1], 1'b0)};
        end else if (r_mode) begin
            w_next_cd = {rotr28(r_cd[56:29], w_rot_two), rotr28(r_cd[28:1], w_rot_two)};
        end else begin
            w_next_cd = {rotl28(r_cd[56:29], w_rot_two), rotl28(r_cd[28:1], w_rot_two)};
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_last       = r_mode ? (subkey_round == 5'd1) : (subkey_round == 5'd16);
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (subkey_ready && w_last) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_mode       <= 1'b0;
            r_cd         <= '0;
            subkey       <= '0;
            subkey_round <= '0;
            subkey_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            r_state <= w_state_next;
            done    <= 1'b0;
            if (r_state == S_IDLE) begin
                if (start) begin
                    r_mode       <= decrypt;
                    r_cd         <= w_next_cd;
                    subkey       <= w_next_subkey;
                    subkey_round <= decrypt ? 5'd16 : 5'd1;
                    subkey_valid <= 1'b1;
                    busy         <= 1'b1;
                end
            end else if (subkey_ready) begin
                if (w_last) begin
                    subkey       <= '0;
                    subkey_round <= '0;
                    subkey_valid <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b1;
                end else begin
                    r_cd         <= w_next_cd;
                    subkey       <= w_next_subkey;
                    subkey_round <= r_mode ? (subkey_round - 5'd1) : (subkey_round + 5'd1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/des_key_sched_seq.md
Name: des_key_sched_seq

Overview:
Sequential DES key schedule that streams the 16 round subkeys one per handshake, for the iterative round engine.
- Encrypt mode: order K1..K16, using left rotations of C/D.
- Decrypt mode: order K16..K1, using right rotations of C/D, so no 16-entry subkey store is needed.
- Uses the same PC-1, PC-2 and shift tables as the combinational key processor. Subkeys are bit-identical to it.

Parameters:
- none (DES tables are fixed constants inside the block)

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request a new schedule; sampled only in IDLE.
- decrypt  in  1  sampled with start; 0 = K1..K16, 1 = K16..K1.
- key_high  in  [32:1]  key bits 64:33; key_high[32] is DES key bit 1.
- key_low  in  [32:1]  key bits 32:1; parity bits are ignored by PC-1.
- subkey  out  [48:1]  current subkey; subkey[48] is PC-2 output bit 1.
- subkey_round  out  [5:1]  round index 1..16 of the presented subkey.
- subkey_valid  out  1  subkey and subkey_round are valid.
- subkey_ready  in  1  consumer accepts when valid & ready.
- busy  out  1  high from the cycle after start acceptance until the last subkey is accepted.
- done  out  1  one-cycle pulse the cycle after the 16th subkey is accepted.

Behaviour:
- Reset (rst=1 at a clock edge), from any state including mid-schedule:
  - Go to IDLE.
  - subkey=0, subkey_round=0, subkey_valid=0, busy=0, done=0, CD register=0, mode=0.
- Tables are standard DES:
  - PC-1 maps 64 to 56 bits; C = bits 56:29, D = bits 28:1.
  - PC-2 maps 56 to 48 bits.
  - shift[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Rotations are 28-bit, applied independently to C and D:
  - rotl by n: C <= {C[28-n:1], C[28:29-n]}.
  - rotr is the inverse.
- States: IDLE, RUN.
- IDLE:
  - If start=1, latch mode=decrypt and compute P = PC1({key_high,key_low}).
  - Encrypt: CD <= rotl(P,1), subkey <= PC2(rotl(P,1)), subkey_round <= 1.
  - Decrypt: CD <= P (C16=C0 because total shift is 28), subkey <= PC2(P), subkey_round <= 16.
  - In both cases: subkey_valid <= 1, busy <= 1, go to RUN.
  - Latency: first subkey is valid exactly 1 cycle after the start edge.
- RUN, with r = subkey_round:
  - subkey_valid=0 never occurs in RUN.
  - Hold: if subkey_ready=0, all outputs and CD stay unchanged (stall of any length).
  - Encrypt advance, on accept with r<16: CD <= rotl(CD, shift[r+1]), subkey <= PC2 of the new CD, r <= r+1.
  - Decrypt advance, on accept with r>1: CD <= rotr(CD, shift[r]), subkey <= PC2 of the new CD, r <= r-1.
  - Final accept (encrypt r=16, or decrypt r=1): subkey_valid <= 0, busy <= 0, done <= 1 for one cycle, subkey/subkey_round <= 0, go to IDLE.
- Throughput: one subkey per cycle with ready held high. 16 subkeys on cycles t+1..t+16, done at t+17.
- start while in RUN: ignored. Key or decrypt changes during RUN: no effect, because only the latched CD is used.
- start in the same cycle that done is high (IDLE): accepted, so back-to-back schedules are possible.
- decrypt changing while start=0: no effect.
- Key inputs need only be stable on the start edge.

Test Plan:
- Key 133457799BBCDFF1, decrypt=0, ready=1:
  - subkey_valid at start+1 with subkey=1B02EFFC7072, round=1.
  - Next cycle 79AED9DBC9E5, round=2.
  - 16th value CB3D8B0E17F5, round=16.
  - done pulses at start+17.
- Same key, decrypt=1:
  - Sequence starts CB3D8B0E17F5 (round 16), then BF918D3D3F0A (round 15).
  - Ends 1B02EFFC7072 (round 1).
  - The full sequence is the exact reverse of the encrypt run.
- Random ready backpressure on both modes:
  - subkey and round stay stable while valid & !ready.
  - The accepted sequence matches the ready=1 runs.
- start pulsed mid-RUN with a different key and decrypt value:
  - Ignored, sequence continues unchanged.
  - start asserted in the done cycle: a new first subkey appears the next cycle.
- rst asserted at round 7:
  - Next cycle: all outputs 0, state IDLE, no done pulse.
  - A subsequent start produces a correct full schedule.
- 200 random keys in both modes:
  - Each subkey compared against the combinational key processor's key1..key16.
